// File: rtl/blake_block_ctrl_pkg.sv
// blake_block_ctrl_pkg: shared state encoding and block geometry for the BLAKE block controller.
package blake_block_ctrl_pkg;
    typedef enum logic [1:0] {FILL, RUN, DRAIN, DONE} state_e;
    localparam int BLOCK_WORDS = 16;
    localparam int ROUND_STEPS = 64;
    localparam int BLOCK_BITS  = 1024;
    // Oversized final-block bit counts saturate to a full block.
    function automatic logic [10:0] clamp_bits(input logic [10:0] b);
        return (b > 11'(BLOCK_BITS)) ? 11'(BLOCK_BITS) : b;
    endfunction
endpackage

// File: rtl/blake_block_ctrl.sv
// blake_block_ctrl: assembles 16x64-bit message words into a block, sequences the round datapath and tracks the bit counter.
module blake_block_ctrl
    import blake_block_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rstb,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [63:0]   s_data,
    input  logic          s_last,
    input  logic [10:0]   s_last_bits,
    output logic [1023:0] msg_block,
    output logic [127:0]  t_ctr,
    output logic          init_load,
    output logic          blk_start,
    output logic          round_ing,
    input  logic          count_done,
    input  logic          rdy,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          err
);
    state_e          state_q;
    logic [3:0]      word_idx_q;
    logic            first_q, last_q, err_q, blk_start_q, init_load_q;
    logic [127:0]    t_acc_q, t_ctr_q, t_acc_d;
    logic [1023:0]   msg_block_q;
    logic            accept, word15, bad_bits;
    logic [10:0]     last_bits;

    assign accept    = s_valid && state_q == FILL;
    assign word15    = accept && word_idx_q == 4'(BLOCK_WORDS - 1);
    assign bad_bits  = word15 && s_last && s_last_bits > 11'(BLOCK_BITS);
    assign last_bits = clamp_bits(s_last_bits);
    assign t_acc_d   = t_acc_q + (s_last ? 128'(last_bits) : 128'(BLOCK_BITS));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= FILL;
            word_idx_q  <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            blk_start_q <= 1'b0;
            init_load_q <= 1'b0;
            t_acc_q     <= '0;
            t_ctr_q     <= '0;
            msg_block_q <= '0;
        end else begin
            blk_start_q <= 1'b0;
            init_load_q <= 1'b0;
            if ((rdy && state_q != DRAIN) || (count_done && state_q != RUN) || bad_bits)
                err_q <= 1'b1;
            case (state_q)
                FILL: if (accept) begin
                    // ~idx == 15-idx places word 0 in the most significant slot
                    msg_block_q[{~word_idx_q, 6'd0} +: 64] <= s_data;
                    word_idx_q <= word_idx_q + 4'd1;
                    if (word15) begin
                        state_q     <= RUN;
                        blk_start_q <= 1'b1;
                        init_load_q <= first_q;
                        first_q     <= 1'b0;
                        last_q      <= s_last;
                        // A padding-only final block reports zero bits and leaves the accumulator alone
                        if (s_last && last_bits == 11'd0) begin
                            t_ctr_q <= '0;
                        end else begin
                            t_acc_q <= t_acc_d;
                            t_ctr_q <= t_acc_d;
                        end
                    end
                end
                RUN:   if (count_done) state_q <= DRAIN;
                DRAIN: if (rdy) state_q <= last_q ? DONE : FILL;
                DONE: if (m_ready) begin
                    state_q <= FILL;
                    first_q <= 1'b1;
                    t_acc_q <= '0;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign s_ready   = state_q == FILL;
    assign round_ing = state_q == RUN;
    assign m_valid   = state_q == DONE;
    assign busy      = !(state_q == FILL && word_idx_q == 4'd0);
    assign err       = err_q;
    assign blk_start = blk_start_q;
    assign init_load = init_load_q;
    assign t_ctr     = t_ctr_q;
    assign msg_block = msg_block_q;
endmodule

// File: tb/tb_blake_block_ctrl.sv
// tb_blake_block_ctrl: directed scoreboard bench for the BLAKE block controller.
module tb_blake_block_ctrl;
    import blake_block_ctrl_pkg::*;

    logic          clk = 1'b0, rstb = 1'b0;
    logic          s_valid = 1'b0, s_last = 1'b0, count_done = 1'b0, rdy = 1'b0, m_ready = 1'b0;
    logic [63:0]   s_data = '0;
    logic [10:0]   s_last_bits = '0;
    logic          s_ready, init_load, blk_start, round_ing, m_valid, busy, err;
    logic [1023:0] msg_block;
    logic [127:0]  t_ctr;

    int errors = 0, checks = 0;

    typedef struct {
        logic [127:0]  t;
        logic          init;
        logic [1023:0] blk;
    } exp_t;
    exp_t sb[$];
    logic [127:0] m_acc = '0;
    logic         m_first = 1'b1;

    blake_block_ctrl dut (
        .clk(clk), .rstb(rstb), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_last_bits(s_last_bits), .msg_block(msg_block), .t_ctr(t_ctr),
        .init_load(init_load), .blk_start(blk_start), .round_ing(round_ing),
        .count_done(count_done), .rdy(rdy), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0; s_valid = 1'b0; s_last = 1'b0; count_done = 1'b0; rdy = 1'b0; m_ready = 1'b0;
        #1;
        chk("rst_blk_start", blk_start, 1'b0);
        chk("rst_init_load", init_load, 1'b0);
        chk("rst_round_ing", round_ing, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_t_ctr", t_ctr, '0);
        chk("rst_msg_zero", msg_block === '0, 1'b1);
        @(negedge clk);
        rstb = 1'b1;
        m_acc = '0; m_first = 1'b1; sb.delete();
        @(negedge clk);
        chk("rel_s_ready", s_ready, 1'b1);
    endtask

    task automatic send_block(input logic [63:0] base, input logic last, input logic [10:0] bits);
        exp_t e;
        logic [10:0] b;
        b = (bits > 11'(BLOCK_BITS)) ? 11'(BLOCK_BITS) : bits;
        for (int i = 0; i < BLOCK_WORDS; i++) e.blk[64*(15-i) +: 64] = base + 64'(i);
        if (last && b == 11'd0) e.t = '0;
        else begin
            m_acc = m_acc + (last ? 128'(b) : 128'(BLOCK_BITS));
            e.t = m_acc;
        end
        e.init = m_first;
        m_first = 1'b0;
        sb.push_back(e);
        chk("fill_s_ready", s_ready, 1'b1);
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            s_valid = 1'b1;
            s_data = base + 64'(i);
            s_last = (i == 15) && last;
            s_last_bits = (i == 15) ? bits : 11'h7ff;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic process_block(input logic last, input logic hold);
        exp_t e;
        int n;
        @(negedge clk);
        e = sb.pop_front();
        chk("blk_start", blk_start, 1'b1);
        chk("init_load", init_load, e.init);
        chk("t_ctr", t_ctr, e.t);
        chk("msg_block", msg_block === e.blk, 1'b1);
        if (hold) begin
            s_valid = 1'b1; s_data = '1; s_last = 1'b1; s_last_bits = 11'd5;
        end
        n = 0;
        repeat (70) begin
            if (round_ing) n++;
            count_done = round_ing && n == ROUND_STEPS;
            @(negedge clk);
        end
        count_done = 1'b0;
        chk("round_cycles", 128'(n), 128'(ROUND_STEPS));
        chk("blk_start_pulse", blk_start, 1'b0);
        chk("drain_s_ready", s_ready, 1'b0);
        chk("drain_busy", busy, 1'b1);
        chk("msg_stable", msg_block === e.blk, 1'b1);
        chk("t_stable", t_ctr, e.t);
        repeat (58) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        if (last) begin
            chk("m_valid", m_valid, 1'b1);
            repeat (2) @(negedge clk);
            chk("m_valid_hold", m_valid, 1'b1);
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            s_valid = 1'b0;
            chk("m_valid_clr", m_valid, 1'b0);
            m_acc = '0;
            m_first = 1'b1;
        end else begin
            chk("no_m_valid", m_valid, 1'b0);
            chk("refill_s_ready", s_ready, 1'b1);
        end
    endtask

    initial begin
        exp_t e;
        do_reset();

        // single full final block
        send_block(64'hA5A5_0000_0000_0000, 1'b1, 11'd1024);
        process_block(1'b1, 1'b0);

        // two-block message, input held valid across RUN/DRAIN of block 1
        send_block(64'h1111_0000_0000_0000, 1'b0, 11'd0);
        process_block(1'b0, 1'b1);
        send_block(64'h2222_0000_0000_0100, 1'b1, 11'd200);
        chk("blk2_t_1224", m_acc, 128'd1224);
        process_block(1'b1, 1'b1);

        // full block then padding-only final block
        send_block(64'h3333_0000_0000_0000, 1'b0, 11'd0);
        process_block(1'b0, 1'b0);
        send_block(64'h4444_0000_0000_0000, 1'b1, 11'd0);
        process_block(1'b1, 1'b0);

        // accumulator restarted after handshake
        send_block(64'h5555_0000_0000_0000, 1'b1, 11'd512);
        process_block(1'b1, 1'b0);

        // stray rdy and m_ready in idle FILL
        rdy = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        rdy = 1'b0; m_ready = 1'b0;
        chk("rdy_fill_err", err, 1'b1);
        chk("rdy_fill_s_ready", s_ready, 1'b1);
        chk("rdy_fill_busy", busy, 1'b0);
        chk("m_ready_ignored", m_valid, 1'b0);
        send_block(64'h6666_0000_0000_0000, 1'b1, 11'd64);
        process_block(1'b1, 1'b0);
        chk("err_sticky", err, 1'b1);
        do_reset();

        // stray count_done in FILL
        count_done = 1'b1;
        @(negedge clk);
        count_done = 1'b0;
        chk("cd_fill_err", err, 1'b1);
        chk("cd_fill_round_ing", round_ing, 1'b0);
        do_reset();

        // oversized final bit count saturates
        send_block(64'h7777_0000_0000_0000, 1'b1, 11'd1500);
        process_block(1'b1, 1'b0);
        chk("bad_bits_err", err, 1'b1);
        do_reset();

        // reset around round step 30
        send_block(64'h8888_0000_0000_0000, 1'b1, 11'd1024);
        @(negedge clk);
        e = sb.pop_front();
        chk("mid_blk_start", blk_start, 1'b1);
        chk("mid_init_load", init_load, e.init);
        repeat (29) @(negedge clk);
        chk("mid_round_ing", round_ing, 1'b1);
        do_reset();
        repeat (70) @(negedge clk);
        chk("abandon_m_valid", m_valid, 1'b0);
        chk("abandon_busy", busy, 1'b0);
        send_block(64'h9999_0000_0000_0000, 1'b1, 11'd100);
        process_block(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/blake_block_ctrl.md
BLAKE_BLOCK_CTRL -- requirements
Module: blake_block_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge system clock.
REQ-002 SHALL have port rstb  input  1  asynchronous active-low reset.
REQ-003 SHALL have port s_valid  input  1  message word valid.
REQ-004 SHALL have port s_ready  output  1  message word accepted when s_valid&&s_ready.
REQ-005 SHALL have port s_data  input  64  message word, first word of block most significant.
REQ-006 SHALL have port s_last  input  1  word belongs to final block of message, sampled on word 15 only.
REQ-007 SHALL have port s_last_bits  input  11  message bits in final block (0..1024), sampled with s_last on word 15.
REQ-008 SHALL have port msg_block  output  1024  assembled block; word k at bits [1023-64k -: 64].
REQ-009 SHALL have port t_ctr  output  128  bit counter for current block.
REQ-010 SHALL have port init_load  output  1  one-cycle pulse: load IV chain value (first block of message).
REQ-011 SHALL have port blk_start  output  1  one-cycle pulse: block compression starts.
REQ-012 SHALL have port round_ing  output  1  advance enable for the 64-step round counter.
REQ-013 SHALL have port count_done  input  1  round counter at index 63.
REQ-014 SHALL have port rdy  input  1  datapath result valid, arrives 64 cycles after count_done.
REQ-015 SHALL have port m_valid / m_ready  output / input  1 / 1  digest-ready handshake.
REQ-016 SHALL have port busy  output  1  high in any state other than FILL with word index 0.
REQ-017 SHALL have port err  output  1  sticky protocol error.

Function
REQ-018 SHALL implement FSM states FILL, RUN, DRAIN, DONE.
REQ-019 FILL: s_ready=1; each accepted word written to msg_block slot word_idx (4-bit), word_idx increments; word 15 accepted -> RUN, word_idx -> 0.
REQ-020 RUN entry cycle SHALL pulse blk_start; same cycle pulse init_load if block is first of its message.
REQ-021 RUN: round_ing=1 every cycle; count_done sampled high -> DRAIN (round_ing low from next cycle); exactly 64 round_ing cycles per block.
REQ-022 DRAIN: round_ing=0, s_ready=0; rdy high -> DONE if block had s_last, else FILL.
REQ-023 DONE: m_valid=1 held until m_ready; on handshake -> FILL, next block flagged first-of-message.
REQ-024 t_ctr SHALL update on word-15 accept: non-last block adds 1024; last block adds s_last_bits; addition modulo 2^128.
REQ-025 Last block with s_last_bits==0 (padding-only) SHALL present t_ctr=0 for that block, accumulator unchanged.
REQ-026 t accumulator SHALL clear to 0 on DONE handshake.
REQ-027 msg_block and t_ctr SHALL remain stable from RUN entry until next FILL word write.
REQ-028 s_valid outside FILL SHALL be ignored (no accept, no error).
REQ-029 rdy outside DRAIN, or count_done outside RUN, SHALL set err; err clears only on reset.
REQ-030 m_ready without m_valid SHALL be ignored.
REQ-031 s_last_bits>1024 SHALL set err and be treated as 1024.

Reset
REQ-032 rstb low SHALL force FILL, word_idx=0, first-flag=1, t=0, msg_block=0, s_ready=1 after release, all other outputs 0, err=0.
REQ-033 Reset mid-RUN/DRAIN SHALL abandon block; no m_valid issued for it.

Structure
REQ-034 Shared package SHALL hold state encoding, BLOCK_WORDS=16, ROUND_STEPS=64, BLOCK_BITS=1024.
REQ-035 Single module; no sub-modules; 128-bit adder inline.

Verification
REQ-036 Single 16-word block, s_last=1, s_last_bits=1024 -> blk_start+init_load one cycle after word 15, round_ing 64 cycles, m_valid after rdy, t_ctr=1024.
REQ-037 Two-block message, bits 1024 then 200 -> block 2 t_ctr=1224, init_load only on block 1.
REQ-038 Padding-only last block (s_last_bits=0) after one full block -> block 2 t_ctr=0.
REQ-039 s_valid held high during RUN/DRAIN -> s_ready=0, no word consumed; word 0 of next block accepted first FILL cycle.
REQ-040 rdy pulsed in FILL -> err=1 sticky; FSM state unchanged.
REQ-041 rstb asserted at round step 30 -> all outputs reset values, next 16 words start new message with init_load.
